// File: rtl/xillyvga_pkg.sv
// Shared types and helpers for the xillyvga scanout path: FSM states,
// pixel packing modes and counter sizing.
package xillyvga_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } scan_state_e;

   localparam int PIX_MODE_XRGB32 = 0;
   localparam int PIX_MODE_RGB565 = 1;

   function automatic int cnt_width(input int total);
      return (total <= 2) ? 1 : $clog2(total);
   endfunction

   // Replicate the top bits into the low bits so full-scale 565 maps to 0xFF.
   function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
      return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
   endfunction

endpackage

// File: rtl/xillyvga_timing_gen.sv
// Horizontal/vertical raster counters with active, sync and frame-end
// decodes. Counters only move while adv is high; clr parks them at 0.
module xillyvga_timing_gen
   import xillyvga_pkg::*;
#(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29
) (
   input  logic clk,
   input  logic rst_n,
   input  logic adv,
   input  logic clr,
   output logic de,
   output logic hs_act,
   output logic vs_act,
   output logic frame_end,
   output logic pix_odd
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = cnt_width(H_TOTAL);
   localparam int VW      = cnt_width(V_TOTAL);

   logic [HW-1:0] hc_q, hc_d;
   logic [VW-1:0] vc_q, vc_d;
   logic          line_end;
   logic          last_line;

   assign line_end  = (int'(hc_q) == H_TOTAL - 1);
   assign last_line = (int'(vc_q) == V_TOTAL - 1);

   always_comb begin
      hc_d = hc_q;
      vc_d = vc_q;
      if (clr) begin
         hc_d = '0;
         vc_d = '0;
      end else if (adv) begin
         if (line_end) begin
            hc_d = '0;
            vc_d = last_line ? '0 : vc_q + VW'(1);
         end else begin
            hc_d = hc_q + HW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   // Region order on both axes: active, front porch, sync, back porch.
   assign de        = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
   assign hs_act    = (int'(hc_q) >= H_ACTIVE + H_FP) &&
                      (int'(hc_q) <  H_ACTIVE + H_FP + H_SYNC);
   assign vs_act    = (int'(vc_q) >= V_ACTIVE + V_FP) &&
                      (int'(vc_q) <  V_ACTIVE + V_FP + V_SYNC);
   assign frame_end = line_end && last_line;
   assign pix_odd   = hc_q[0];

endmodule

// File: rtl/xillyvga_scanout_timing.sv
// Scanout stage: run/stop FSM around the raster generator, framebuffer word
// demand and unpacking, sticky underflow and registered VGA pin outputs.
module xillyvga_scanout_timing
   import xillyvga_pkg::*;
#(
   parameter int H_ACTIVE  = 1024,
   parameter int H_FP      = 24,
   parameter int H_SYNC    = 136,
   parameter int H_BP      = 160,
   parameter int V_ACTIVE  = 768,
   parameter int V_FP      = 3,
   parameter int V_SYNC    = 6,
   parameter int V_BP      = 29,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int PIX_MODE  = 0
) (
   input  logic        m_axi_aclk,
   input  logic        m_axi_aresetn,
   input  logic        enable,
   input  logic [31:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        frame_start,
   output logic        underflow,
   input  logic        underflow_clr,
   output logic        running,
   output logic [7:0]  vga_red,
   output logic [7:0]  vga_green,
   output logic [7:0]  vga_blue,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_de,
   output logic [1:0]  dbg_state
);

   if (PIX_MODE == PIX_MODE_RGB565 && (H_ACTIVE % 2) != 0) begin : g_bad_hactive
      $error("xillyvga_scanout_timing: H_ACTIVE must be even in RGB565 mode");
   end
   if (PIX_MODE != PIX_MODE_XRGB32 && PIX_MODE != PIX_MODE_RGB565) begin : g_bad_mode
      $error("xillyvga_scanout_timing: PIX_MODE must be 0 or 1");
   end

   localparam logic HS_ON = 1'(HSYNC_POL);
   localparam logic VS_ON = 1'(VSYNC_POL);

   scan_state_e state_q, state_d;
   logic        frame_start_q, frame_start_d;
   logic        underflow_q, underflow_d;
   logic [15:0] hi_q, hi_d;
   logic        hi_ok_q, hi_ok_d;
   logic [23:0] rgb_q, rgb_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        de_q, de_d;

   logic        run_w;
   logic        de_raw, hs_act, vs_act, frame_end, pix_odd;
   logic        de;
   logic        demand;

   assign run_w = (state_q != IDLE);

   xillyvga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk       (m_axi_aclk),
      .rst_n     (m_axi_aresetn),
      .adv       (run_w),
      .clr       (!run_w),
      .de        (de_raw),
      .hs_act    (hs_act),
      .vs_act    (vs_act),
      .frame_end (frame_end),
      .pix_odd   (pix_odd)
   );

   // Counters sit at (0,0) while idle, which decodes as active; gate it.
   assign de     = de_raw && run_w;
   assign demand = de && ((PIX_MODE == PIX_MODE_XRGB32) || !pix_odd);

   // Registered frame_start lands on the first cycle of the new frame.
   always_comb begin
      state_d       = state_q;
      frame_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d       = RUN;
               frame_start_d = 1'b1;
            end
         end
         RUN: begin
            if (frame_end) frame_start_d = 1'b1;
            if (!enable)   state_d       = STOPPING;
         end
         STOPPING: begin
            if (enable)         state_d = RUN;
            else if (frame_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A missing word blanks its pixel(s); the stream is never re-aligned.
   always_comb begin
      rgb_d   = 24'h000000;
      hi_d    = hi_q;
      hi_ok_d = hi_ok_q;
      if (PIX_MODE == PIX_MODE_XRGB32) begin
         if (demand && pix_valid) rgb_d = pix_data[23:0];
      end else begin
         if (demand) begin
            hi_d    = pix_data[31:16];
            hi_ok_d = pix_valid;
            if (pix_valid) rgb_d = rgb565_to_rgb888(pix_data[15:0]);
         end else if (de && hi_ok_q) begin
            rgb_d = rgb565_to_rgb888(hi_q);
         end
      end
   end

   always_comb begin
      underflow_d = (underflow_q && !underflow_clr) || (demand && !pix_valid);
      hsync_d     = (run_w && hs_act) ? HS_ON : ~HS_ON;
      vsync_d     = (run_w && vs_act) ? VS_ON : ~VS_ON;
      de_d        = de;
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         state_q       <= IDLE;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
         hi_q          <= 16'h0000;
         hi_ok_q       <= 1'b0;
         rgb_q         <= 24'h000000;
         hsync_q       <= ~HS_ON;
         vsync_q       <= ~VS_ON;
         de_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
         hi_q          <= hi_d;
         hi_ok_q       <= hi_ok_d;
         rgb_q         <= rgb_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
      end
   end

   assign pix_ready   = demand;
   assign frame_start = frame_start_q;
   assign underflow   = underflow_q;
   assign running     = run_w;
   assign vga_red     = rgb_q[23:16];
   assign vga_green   = rgb_q[15:8];
   assign vga_blue    = rgb_q[7:0];
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign vga_de      = de_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_xillyvga_scanout_timing.sv
// Bench for xillyvga_scanout_timing: an XRGB32 and an RGB565 instance share
// stimulus and are tracked by a frame-position reference model.
module tb_xillyvga_scanout_timing;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, enable, pix_valid, underflow_clr;
   logic [31:0] pix_data;

   logic       d0_ready, d0_fs, d0_uf, d0_run, d0_hs, d0_vs, d0_de;
   logic [7:0] d0_r, d0_g, d0_b;
   logic [1:0] d0_dbg;
   logic       d1_ready, d1_fs, d1_uf, d1_run, d1_hs, d1_vs, d1_de;
   logic [7:0] d1_r, d1_g, d1_b;
   logic [1:0] d1_dbg;

   xillyvga_scanout_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(0), .VSYNC_POL(0), .PIX_MODE(0)
   ) dut0 (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .enable(enable),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(d0_ready),
      .frame_start(d0_fs), .underflow(d0_uf), .underflow_clr(underflow_clr),
      .running(d0_run), .vga_red(d0_r), .vga_green(d0_g), .vga_blue(d0_b),
      .vga_hsync(d0_hs), .vga_vsync(d0_vs), .vga_de(d0_de), .dbg_state(d0_dbg)
   );

   xillyvga_scanout_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(0), .VSYNC_POL(0), .PIX_MODE(1)
   ) dut1 (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .enable(enable),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(d1_ready),
      .frame_start(d1_fs), .underflow(d1_uf), .underflow_clr(underflow_clr),
      .running(d1_run), .vga_red(d1_r), .vga_green(d1_g), .vga_blue(d1_b),
      .vga_hsync(d1_hs), .vga_vsync(d1_vs), .vga_de(d1_de), .dbg_state(d1_dbg)
   );

   logic        o_ready[2], o_fs[2], o_uf[2], o_run[2], o_hs[2], o_vs[2], o_de[2];
   logic [23:0] o_rgb[2];
   assign o_ready[0] = d0_ready;  assign o_ready[1] = d1_ready;
   assign o_fs[0]    = d0_fs;     assign o_fs[1]    = d1_fs;
   assign o_uf[0]    = d0_uf;     assign o_uf[1]    = d1_uf;
   assign o_run[0]   = d0_run;    assign o_run[1]   = d1_run;
   assign o_hs[0]    = d0_hs;     assign o_hs[1]    = d1_hs;
   assign o_vs[0]    = d0_vs;     assign o_vs[1]    = d1_vs;
   assign o_de[0]    = d0_de;     assign o_de[1]    = d1_de;
   assign o_rgb[0]   = {d0_r, d0_g, d0_b};
   assign o_rgb[1]   = {d1_r, d1_g, d1_b};

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: frame position as one linear index plus run/stop flags.
   bit          m_run, m_stop;
   int          m_pos;
   logic [15:0] m_hi[2];
   bit          m_hi_ok[2];
   bit          m_uf[2];
   logic [23:0] e_rgb[2];
   bit          e_de, e_hs, e_vs, e_fs, e_run;

   typedef struct {
      logic [31:0] word;
      logic [23:0] exp_m0;
      logic [23:0] exp_lo;
      logic [23:0] exp_hi;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] px565(input logic [15:0] w);
      int r, g, b;
      r = int'(w[15:11]);
      g = int'(w[10:5]);
      b = int'(w[4:0]);
      return 24'((((r * 8) + (r / 4)) << 16) | (((g * 4) + (g / 16)) << 8) | ((b * 8) + (b / 4)));
   endfunction

   function automatic bit model_demand(input int m);
      int h, v;
      h = m_pos % HT;
      v = m_pos / HT;
      return (m_run || m_stop) && h < HA && v < VA && (m == 0 || (h % 2) == 0);
   endfunction

   // One clock: check pix_ready, advance the model, check registered outputs.
   task automatic cycle();
      bit act, de, dem;
      int h, v;
      #1;
      for (int m = 0; m < 2; m++)
         chk($sformatf("pix_ready_m%0d", m), 32'(o_ready[m]), 32'(model_demand(m)));
      act = m_run || m_stop;
      h   = m_pos % HT;
      v   = m_pos / HT;
      de  = act && h < HA && v < VA;
      if (!rst_n) begin
         m_run = 0; m_stop = 0; m_pos = 0;
         for (int m = 0; m < 2; m++) begin
            m_hi_ok[m] = 0; m_uf[m] = 0; e_rgb[m] = 24'h0;
         end
         e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_run = 0;
      end else begin
         for (int m = 0; m < 2; m++) begin
            dem      = model_demand(m);
            e_rgb[m] = 24'h0;
            if (m == 0) begin
               if (dem && pix_valid) e_rgb[0] = pix_data[23:0];
            end else if (dem) begin
               if (pix_valid) e_rgb[1] = px565(pix_data[15:0]);
               m_hi[1]    = pix_data[31:16];
               m_hi_ok[1] = pix_valid;
            end else if (de && m_hi_ok[1]) begin
               e_rgb[1] = px565(m_hi[1]);
            end
            m_uf[m] = (m_uf[m] && !underflow_clr) || (dem && !pix_valid);
         end
         e_de = de;
         e_hs = !(act && h >= HA + HF && h < HA + HF + HS);
         e_vs = !(act && v >= VA + VF && v < VA + VF + VS);
         e_fs = (!act && enable) || (m_run && m_pos == FT - 1);
         if (!act) begin
            if (enable) m_run = 1;
         end else if (m_run) begin
            if (!enable) begin m_run = 0; m_stop = 1; end
         end else begin
            if (enable) begin m_stop = 0; m_run = 1; end
            else if (m_pos == FT - 1) m_stop = 0;
         end
         m_pos = act ? (m_pos + 1) % FT : 0;
         e_run = m_run || m_stop;
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rgb_m%0d", m),       32'(o_rgb[m]), 32'(e_rgb[m]));
         chk($sformatf("de_m%0d", m),        32'(o_de[m]),  32'(e_de));
         chk($sformatf("hsync_m%0d", m),     32'(o_hs[m]),  32'(e_hs));
         chk($sformatf("vsync_m%0d", m),     32'(o_vs[m]),  32'(e_vs));
         chk($sformatf("frame_start_m%0d", m), 32'(o_fs[m]), 32'(e_fs));
         chk($sformatf("underflow_m%0d", m), 32'(o_uf[m]),  32'(m_uf[m]));
         chk($sformatf("running_m%0d", m),   32'(o_run[m]), 32'(e_run));
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic restart();
      rst_n = 0; enable = 0; pix_valid = 1; underflow_clr = 0;
      cycle();
      rst_n = 1; enable = 1;
      cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fs_cnt, de_cnt, hs_low, vs_low, rdy0, rdy1, w, n;
      logic [31:0] k;

      vecs[0] = '{32'h00112233, 24'h112233, 24'h21459C, 24'h00008C};
      vecs[1] = '{32'hF800001F, 24'h00001F, 24'h0000FF, 24'hFF0000};
      vecs[2] = '{32'hFFFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
      vecs[3] = '{32'h07E00000, 24'hE00000, 24'h000000, 24'h00FF00};
      vecs[4] = '{32'h12345678, 24'h345678, 24'h52CFC6, 24'h1045A5};

      rst_n = 0; enable = 0; pix_valid = 0; underflow_clr = 0; pix_data = 32'h0;
      m_run = 0; m_stop = 0; m_pos = 0;
      @(posedge clk);
      #1;
      cycle();
      chk("reset_hsync", 32'(d0_hs), 32'd1);
      chk("reset_vsync", 32'(d0_vs), 32'd1);
      chk("reset_de", 32'(d0_de), 32'd0);
      chk("reset_running", 32'(d0_run), 32'd0);

      // Sanity frame with a mode-0 word stream, always valid.
      rst_n = 1; enable = 1; pix_valid = 1;
      w = 0;
      pix_data = 32'h00112233;
      cycle();
      fs_cnt = int'(d0_fs); de_cnt = 0; hs_low = 0; vs_low = 0; rdy0 = 0; rdy1 = 0;
      for (int i = 0; i < FT; i++) begin
         rdy0 += int'(d0_ready);
         rdy1 += int'(d1_ready);
         if (d0_ready) w++;
         cycle();
         pix_data = 32'h00112233 + 32'(w) * 32'h00333333;
         if (i == 0) chk("first_pixel_m0", 32'(o_rgb[0]), 32'h112233);
         if (i < FT - 1) fs_cnt += int'(d0_fs);
         de_cnt += int'(d0_de);
         hs_low += int'(!d0_hs);
         vs_low += int'(!d0_vs);
      end
      chk("frame_start_count", fs_cnt, 1);
      chk("frame_start_wrap", 32'(d0_fs), 32'd1);
      chk("de_count", de_cnt, 12);
      chk("hsync_low_count", hs_low, 12);
      chk("vsync_low_count", vs_low, 8);
      chk("ready_count_m0", rdy0, 12);
      chk("ready_count_m1", rdy1, 6);

      // Colour unpack table: first word of a fresh frame.
      foreach (vecs[i]) begin
         restart();
         pix_data = vecs[i].word;
         cycle();
         chk($sformatf("vec%0d_m0", i), 32'(o_rgb[0]), 32'(vecs[i].exp_m0));
         chk($sformatf("vec%0d_m1_lo", i), 32'(o_rgb[1]), 32'(vecs[i].exp_lo));
         pix_data = $urandom;
         cycle();
         chk($sformatf("vec%0d_m1_hi", i), 32'(o_rgb[1]), 32'(vecs[i].exp_hi));
      end

      // Underflow at pixel 2 of line 1 (position 10).
      restart();
      run_cycles(10);
      pix_valid = 0; pix_data = 32'hFFFFFFFF;
      cycle();
      chk("uf_pixel_m0", 32'(o_rgb[0]), 32'h0);
      chk("uf_pixel_m1", 32'(o_rgb[1]), 32'h0);
      chk("uf_flag_m0", 32'(d0_uf), 32'd1);
      chk("uf_flag_m1", 32'(d1_uf), 32'd1);
      pix_valid = 1;
      cycle();
      chk("uf_partner_m1", 32'(o_rgb[1]), 32'h0);
      chk("uf_partner_m0", 32'(o_rgb[0]), 32'hFFFFFF);
      run_cycles(5);
      chk("uf_sticky", 32'(d0_uf), 32'd1);
      underflow_clr = 1;
      cycle();
      underflow_clr = 0;
      chk("uf_cleared", 32'(d0_uf), 32'd0);
      n = 0;
      while (!d0_ready && n < 2 * FT) begin
         cycle();
         n++;
      end
      chk("demand_found", 32'(d0_ready), 32'd1);
      underflow_clr = 1; pix_valid = 0;
      cycle();
      underflow_clr = 0; pix_valid = 1;
      chk("uf_clr_collide", 32'(d0_uf), 32'd1);

      // Stop at vc=1: frame completes, then idle.
      restart();
      run_cycles(8);
      enable = 0; fs_cnt = 0;
      for (int i = 0; i < 39; i++) begin
         cycle();
         fs_cnt += int'(d0_fs);
      end
      chk("stopping_running", 32'(d0_run), 32'd1);
      cycle();
      fs_cnt += int'(d0_fs);
      chk("stopped_running", 32'(d0_run), 32'd0);
      chk("stopping_no_fs", fs_cnt, 0);

      // Restart, stop, re-enable before the end: no gap.
      enable = 1;
      cycle();
      chk("restart_fs", 32'(d0_fs), 32'd1);
      run_cycles(8);
      enable = 0;
      run_cycles(12);
      enable = 1; fs_cnt = 0;
      for (int i = 0; i < 27; i++) begin
         cycle();
         fs_cnt += int'(d0_fs);
      end
      chk("reenable_no_fs", fs_cnt, 0);
      cycle();
      chk("reenable_boundary_fs", 32'(d0_fs), 32'd1);

      // Reset mid-line at hc=2, vc=1.
      restart();
      run_cycles(10);
      rst_n = 0;
      cycle();
      chk("midrst_running", 32'(d0_run), 32'd0);
      chk("midrst_de", 32'(d1_de), 32'd0);
      chk("midrst_hsync", 32'(d1_hs), 32'd1);
      chk("midrst_rgb", 32'(o_rgb[0]), 32'h0);
      rst_n = 1;
      cycle();
      chk("midrst_resume_fs", 32'(d0_fs), 32'd1);

      // Randomized soak against the model.
      for (int i = 0; i < 700; i++) begin
         k             = $urandom;
         rst_n         = ($urandom_range(0, 199) != 0);
         enable        = ($urandom_range(0, 15) != 0);
         pix_valid     = ($urandom_range(0, 9) != 0);
         underflow_clr = ($urandom_range(0, 19) == 0);
         pix_data      = k;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
